fu_issue_arbiter: RTL and testbench
===================================

// Module: fu_issue_arbiter
// PURPOSE
//  Shares one pipelined functional unit (FU) among NUM_RS reservation stations (RS).
//  - Each cycle, grants at most one requesting RS by deasserting only that RS's busy line.
//  - Captures the dispatched op into a small FIFO and presents it to the FU with valid/ready.
//  - Sits between the RS array and FU stage 1; all outputs are registered.
// PARAMETERS
//  NUM_RS     4  number of reservation stations sharing the FU (2..8)
//  BUF_DEPTH  3  issue FIFO depth; minimum 3, needed for 1 op/cycle throughput
// PORTS
//  clk             in   1           clock, all logic on posedge
//  rst_n           in   1           asynchronous reset, active low
//  flush           in   1           squash: drop buffered, in-flight and incoming ops
//  rs_req          in   NUM_RS      RS[i] holds at least one operand-ready entry
//  rs_busy         out  NUM_RS      to RS[i] is_functional_unit_busy; 0 = granted this cycle
//  rs_valid        in   NUM_RS      RS[i] out_valid (registered, arrives 1 cycle after grant)
//  rs_instr_index  in   NUM_RS*4    per-RS ROB index, flattened, RS0 in the LSBs
//  rs_instr_full   in   NUM_RS*16   per-RS 16-bit instruction, flattened
//  rs_val1         in   NUM_RS*16   per-RS operand 1 value, flattened
//  rs_val2         in   NUM_RS*16   per-RS operand 2 value, flattened
//  fu_valid        out  1           FIFO head valid toward the FU
//  fu_ready        in   1           FU stage 1 accepts the head this cycle
//  fu_instr_index  out  4           head ROB index
//  fu_instr_full   out  16          head instruction
//  fu_val1         out  16          head operand 1
//  fu_val2         out  16          head operand 2
//  protocol_err    out  1           sticky error flag; cleared only by reset
// BEHAVIOUR
//  - Reset values: rs_busy all 1s, fu_valid 0, fu_* data 0, protocol_err 0, rr pointer 0, FIFO empty, inflight 0.
//  - Grant rule in cycle t:
//    - Grant when !flush, |rs_req, and occ + inflight <= BUF_DEPTH-1.
//    - occ is the FIFO count. inflight is 1 if a grant was given in cycle t-1.
//    - The winner is the first rs_req[i] at or after rr_ptr, in cyclic order.
//    - rs_busy = ~onehot(winner), or all 1s when there is no grant. rs_busy is a registered output.
//    - rr_ptr becomes winner+1 mod NUM_RS. It does not change when there is no grant.
//  - Capture:
//    - In cycle t+1, rs_valid[winner] is pushed into the FIFO, which is visible at fu_valid in t+2.
//    - Latency from RS valid to fu_valid is 1 cycle.
//    - If the granted RS sends no valid, the grant is consumed silently.
//  - FU handshake:
//    - The head is popped on fu_valid & fu_ready.
//    - fu_* data is held stable while fu_valid & !fu_ready.
//    - A push and a pop in the same cycle leave occ unchanged.
//    - With fu_ready tied high, 1 op/cycle is sustained.
//  - Protocol errors:
//    - Error cases: any rs_valid[j] with j != the grant issued last cycle; more than one rs_valid bit set; a push while occ==BUF_DEPTH and no pop.
//    - On error: set protocol_err and drop the offending data. A legal granted op arriving in the same cycle is still pushed.
//  - Flush:
//    - Effective on the next edge: FIFO empties, fu_valid becomes 0, inflight clears.
//    - rs_valid arriving in the flush cycle, or in the cycle after it (a stale grant), is dropped without error.
//    - rr_ptr is kept. rs_busy is all 1s for the flush cycle's grant.
//  - Reset asserted mid-operation: all state returns to reset values immediately (asynchronously). In-flight ops are lost.
// CONFIGURATION
//  - ISSUE_ARB_PERF_EN defined:
//    - Adds outputs perf_grants[15:0] and perf_stalls[15:0], both saturating counters.
//    - perf_grants counts +1 per grant.
//    - perf_stalls counts +1 per cycle with |rs_req and no grant.
//    - Both reset to 0 and are cleared by flush.
//  - ISSUE_ARB_PERF_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package ooo_pkg: ROB_IDX_W=4, INSTR_W=16, DATA_W=16, and typedef struct issue_op_t {idx, instr, val1, val2}.
//  - Sub-module rr_arbiter #(N): combinational round-robin pick.
//    - Inputs: req[N], ptr. Outputs: gnt_onehot[N], gnt_id, any.
//  - FIFO kept inline in this module as an issue_op_t array with head/tail/count.
// TESTING
//  1. Reset:
//     - Stimulus: rs_req=4'b1111 held during reset.
//     - Response: rs_busy=4'b1111, fu_valid=0. First grant is RS0 in the first cycle after reset release.
//  2. Round-robin:
//     - Stimulus: rs_req=4'b1111, fu_ready=1, each RS returns valid when granted.
//     - Response: grants 0,1,2,3,0. fu_valid continuous from cycle 3. fu_instr_index in grant order.
//  3. Backpressure:
//     - Stimulus: fu_ready=0 for 6 cycles, all requesting.
//     - Response: grants stop after 3 ops are buffered. Head held stable. No loss after fu_ready=1, and pops resume 1/cycle.
//  4. Protocol error:
//     - Stimulus: rs_valid=4'b0100 while the last grant was RS1.
//     - Response: protocol_err=1 next cycle. Op not forwarded. Flag stays set until rst_n.
//  5. Flush:
//     - Stimulus: 2 ops buffered plus 1 in flight, then pulse flush.
//     - Response: fu_valid=0 next cycle. Stale valid dropped. protocol_err stays 0.
//  6. Async reset mid-stream:
//     - Stimulus: drop rst_n between clock edges during test 2.
//     - Response: outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fu_issue_arbiter_pkg.sv
// Shared widths and the issue-op record for the out-of-order issue path.
package ooo_pkg;
  localparam int ROB_IDX_W = 4;
  localparam int INSTR_W   = 16;
  localparam int DATA_W    = 16;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] idx;
    logic [INSTR_W-1:0]   instr;
    logic [DATA_W-1:0]    val1;
    logic [DATA_W-1:0]    val2;
  } issue_op_t;
endpackage

// File: rtl/fu_issue_arbiter_if.sv
// RS-array and FU-stage-1 handshake bundle; slave is the arbiter side, master the RS/FU side.
interface fu_issue_arbiter_if
  import ooo_pkg::*;
#(
  parameter int NUM_RS = 4
);
  logic [NUM_RS-1:0]           rs_req;
  logic [NUM_RS-1:0]           rs_busy;
  logic [NUM_RS-1:0]           rs_valid;
  logic [NUM_RS*ROB_IDX_W-1:0] rs_instr_index;
  logic [NUM_RS*INSTR_W-1:0]   rs_instr_full;
  logic [NUM_RS*DATA_W-1:0]    rs_val1;
  logic [NUM_RS*DATA_W-1:0]    rs_val2;
  logic                        fu_valid;
  logic                        fu_ready;
  logic [ROB_IDX_W-1:0]        fu_instr_index;
  logic [INSTR_W-1:0]          fu_instr_full;
  logic [DATA_W-1:0]           fu_val1;
  logic [DATA_W-1:0]           fu_val2;

  modport master (
    output rs_req, rs_valid, rs_instr_index, rs_instr_full, rs_val1, rs_val2, fu_ready,
    input  rs_busy, fu_valid, fu_instr_index, fu_instr_full, fu_val1, fu_val2
  );

  modport slave (
    input  rs_req, rs_valid, rs_instr_index, rs_instr_full, rs_val1, rs_val2, fu_ready,
    output rs_busy, fu_valid, fu_instr_index, fu_instr_full, fu_val1, fu_val2
  );
endinterface

// File: rtl/fu_issue_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, cyclically; zero latency, no backpressure.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);
  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                               = 1'b1;
        gnt_id                            = ID_W'((int'(ptr) + k) % N);
        gnt_onehot[(int'(ptr) + k) % N]   = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fu_issue_arbiter.sv
// Shares one pipelined FU among NUM_RS stations; RS valid reaches fu_valid 1 cycle later, FIFO holds while !fu_ready.
// Grants stop once buffered + in-flight ops would fill the FIFO. ISSUE_ARB_PERF_EN adds grant/stall counters.
module fu_issue_arbiter
  import ooo_pkg::*;
#(
  parameter int NUM_RS    = 4,
  parameter int BUF_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  fu_issue_arbiter_if.slave bus,
  output logic              protocol_err
`ifdef ISSUE_ARB_PERF_EN
  ,
  output logic [15:0]       perf_grants,
  output logic [15:0]       perf_stalls
`endif
);
  localparam int ID_W  = $clog2(NUM_RS);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic [ID_W-1:0]   rr_ptr, last_id, win_id;
  logic [NUM_RS-1:0] win_onehot, rs_busy_q, exp_mask;
  logic              win_any, grant, inflight, flush_d;
  logic              ignore_in, legal_vld, stray, multi, full, overflow, push, pop, err;
  logic              fu_valid_q, protocol_err_q;
  issue_op_t         mem [BUF_DEPTH];
  issue_op_t         in_op, head_op_n, fu_op_q;
  logic [PTR_W-1:0]  head, tail, head_n;
  logic [CNT_W-1:0]  count, count_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == BUF_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] p);
    return (int'(p) == NUM_RS - 1) ? '0 : p + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_RS)) u_rr (
    .req        (bus.rs_req),
    .ptr        (rr_ptr),
    .gnt_onehot (win_onehot),
    .gnt_id     (win_id),
    .any        (win_any)
  );

  // Reserve a slot for the op still in flight so a legal push can never overflow.
  assign grant = !flush && win_any && (int'(count) + int'(inflight) <= BUF_DEPTH - 1);

  assign exp_mask  = inflight ? ~rs_busy_q : '0;
  assign ignore_in = flush || flush_d;
  assign legal_vld = inflight && bus.rs_valid[last_id];
  assign stray     = |(bus.rs_valid & ~exp_mask);
  assign multi     = !$onehot0(bus.rs_valid);
  assign pop       = fu_valid_q && bus.fu_ready;
  assign full      = (int'(count) == BUF_DEPTH);
  assign overflow  = legal_vld && full && !pop;
  assign push      = !ignore_in && legal_vld && !overflow;
  assign err       = !ignore_in && (stray || multi || overflow);

  always_comb begin
    in_op.idx   = bus.rs_instr_index[last_id*ROB_IDX_W +: ROB_IDX_W];
    in_op.instr = bus.rs_instr_full[last_id*INSTR_W +: INSTR_W];
    in_op.val1  = bus.rs_val1[last_id*DATA_W +: DATA_W];
    in_op.val2  = bus.rs_val2[last_id*DATA_W +: DATA_W];
  end

  // Next head entry: an empty FIFO's head slot is the one being written this cycle.
  always_comb begin
    head_n = pop ? ptr_inc(head) : head;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
    head_op_n = (push && head_n == tail) ? in_op : mem[head_n];
  end

  always_ff @(posedge clk) begin
    if (push) mem[tail] <= in_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      last_id        <= '0;
      inflight       <= 1'b0;
      flush_d        <= 1'b0;
      rs_busy_q      <= '1;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      fu_valid_q     <= 1'b0;
      fu_op_q        <= '0;
      protocol_err_q <= 1'b0;
    end else begin
      flush_d   <= flush;
      inflight  <= grant;
      rs_busy_q <= grant ? ~win_onehot : '1;
      if (err) protocol_err_q <= 1'b1;
      if (grant) begin
        rr_ptr  <= id_inc(win_id);
        last_id <= win_id;
      end
      if (flush) begin
        head       <= '0;
        tail       <= '0;
        count      <= '0;
        fu_valid_q <= 1'b0;
      end else begin
        if (push) tail <= ptr_inc(tail);
        head       <= head_n;
        count      <= count_n;
        fu_valid_q <= (count_n != '0);
        if (count_n != '0) fu_op_q <= head_op_n;
      end
    end
  end

  assign bus.rs_busy        = rs_busy_q;
  assign bus.fu_valid       = fu_valid_q;
  assign bus.fu_instr_index = fu_op_q.idx;
  assign bus.fu_instr_full  = fu_op_q.instr;
  assign bus.fu_val1        = fu_op_q.val1;
  assign bus.fu_val2        = fu_op_q.val2;
  assign protocol_err       = protocol_err_q;

`ifdef ISSUE_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else if (flush) begin
      perf_grants <= '0;
      perf_stalls <= '0;
    end else begin
      if (grant && perf_grants != '1) perf_grants <= perf_grants + 1'b1;
      if (win_any && !grant && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_fu_issue_arbiter.sv
// Directed + randomized bench for fu_issue_arbiter against a queue-based reference model.
module tb_fu_issue_arbiter;
  import ooo_pkg::*;

  localparam int N = 4;
  localparam int D = 3;

  logic clk, rst_n, flush, protocol_err;
`ifdef ISSUE_ARB_PERF_EN
  logic [15:0] perf_grants, perf_stalls;
`endif

  fu_issue_arbiter_if #(.NUM_RS(N)) bus ();

  fu_issue_arbiter #(.NUM_RS(N), .BUF_DEPTH(D)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus),
    .protocol_err (protocol_err)
`ifdef ISSUE_ARB_PERF_EN
    ,
    .perf_grants  (perf_grants),
    .perf_stalls  (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: queue of buffered ops, pending grant id, priority pointer.
  issue_op_t mq[$];
  int        m_rr;
  int        m_prev_gnt;
  bit        m_err;
  bit        m_flush_prev;
  logic [N-1:0] exp_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr         = 0;
    m_prev_gnt   = -1;
    m_err        = 1'b0;
    m_flush_prev = 1'b0;
    exp_busy     = '1;
  endtask

  task automatic model_step();
    int occ;
    int g;
    bit popped;
    bit stray;
    bit legal;
    issue_op_t op;
    occ = mq.size();
    g   = -1;
    if (!flush && bus.rs_req != '0 && occ + ((m_prev_gnt >= 0) ? 1 : 0) <= D - 1) begin
      for (int k = 0; k < N; k++) begin
        int i = (m_rr + k) % N;
        if (g < 0 && bus.rs_req[i]) g = i;
      end
    end
    popped = (occ > 0) && bus.fu_ready;
    if (flush) begin
      mq.delete();
    end else begin
      if (popped) void'(mq.pop_front());
      if (!m_flush_prev) begin
        stray = 1'b0;
        for (int j = 0; j < N; j++)
          if (bus.rs_valid[j] && j != m_prev_gnt) stray = 1'b1;
        legal = (m_prev_gnt >= 0) && bus.rs_valid[m_prev_gnt];
        if ($countones(bus.rs_valid) > 1 || stray) m_err = 1'b1;
        if (legal) begin
          if (occ == D && !popped) m_err = 1'b1;
          else begin
            op.idx   = bus.rs_instr_index[m_prev_gnt*4 +: 4];
            op.instr = bus.rs_instr_full[m_prev_gnt*16 +: 16];
            op.val1  = bus.rs_val1[m_prev_gnt*16 +: 16];
            op.val2  = bus.rs_val2[m_prev_gnt*16 +: 16];
            mq.push_back(op);
          end
        end
      end
    end
    m_prev_gnt   = g;
    m_flush_prev = flush;
    if (g >= 0) m_rr = (g + 1) % N;
    exp_busy = (g >= 0) ? ~(4'b0001 << g) : 4'b1111;
  endtask

  task automatic check_outputs();
    check("busy", 64'(bus.rs_busy), 64'(exp_busy));
    check("fu_valid", 64'(bus.fu_valid), 64'(mq.size() > 0));
    check("protocol_err", 64'(protocol_err), 64'(m_err));
    if (mq.size() > 0)
      check("fu_data", 64'({bus.fu_instr_index, bus.fu_instr_full, bus.fu_val1, bus.fu_val2}),
            64'(mq[0]));
  endtask

  // RS side: granted station answers with fresh random data unless told otherwise.
  task automatic drive_rs(input bit respond, input bit ovr_en, input logic [N-1:0] ovr);
    bus.rs_instr_index = 16'($urandom);
    bus.rs_instr_full  = {$urandom, $urandom};
    bus.rs_val1        = {$urandom, $urandom};
    bus.rs_val2        = {$urandom, $urandom};
    if (ovr_en) bus.rs_valid = ovr;
    else if (respond && m_prev_gnt >= 0) bus.rs_valid = 4'b0001 << m_prev_gnt;
    else bus.rs_valid = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    model_reset();
    bus.rs_valid = '0;
    @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.rs_busy), 64'hF);
    check("rst_fu_valid", 64'(bus.fu_valid), 64'h0);
    check("rst_fu_data", 64'({bus.fu_instr_index, bus.fu_instr_full, bus.fu_val1, bus.fu_val2}), 64'h0);
    check("rst_protocol_err", 64'(protocol_err), 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_rs(1'b1, 1'b0, '0);
  endtask

  function automatic int busy_to_id(input logic [N-1:0] b);
    int id = -1;
    for (int i = 0; i < N; i++) if (b[i] == 1'b0 && id < 0) id = i;
    return id;
  endfunction

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int sg;

    // Reset with every RS requesting
    rst_n = 1'b0;
    flush = 1'b0;
    bus.rs_req   = 4'b1111;
    bus.fu_ready = 1'b1;
    bus.rs_valid = '0;
    drive_rs(1'b0, 1'b0, '0);
    do_reset();

    // Round-robin at full throughput
    for (int n = 1; n <= 5; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      if (n > 1) ;
      cycle();
      check("rr_order", 64'(busy_to_id(bus.rs_busy)), 64'(exp_rr[n-1]));
      if (n >= 2) check("fu_valid_continuous", 64'(bus.fu_valid), 64'h1);
    end
    for (int n = 0; n < 4; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end

    // Backpressure: FU stalls for 6 cycles
    bus.fu_ready = 1'b0;
    for (int n = 0; n < 6; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end
    check("bp_grants_stopped", 64'(bus.rs_busy), 64'hF);
    check("bp_fu_valid_held", 64'(bus.fu_valid), 64'h1);
    bus.fu_ready = 1'b1;
    bus.rs_req   = 4'b0000;
    for (int n = 0; n < 6; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end
    check("bp_drained", 64'(bus.fu_valid), 64'h0);

    // Protocol error: RS2 answers a grant given to RS1
    bus.rs_req = 4'b0010;
    drive_rs(1'b1, 1'b0, '0);
    cycle();
    check("perr_setup_gnt_rs1", 64'(bus.rs_busy), 64'hD);
    bus.rs_req = 4'b0000;
    drive_rs(1'b1, 1'b1, 4'b0100);
    cycle();
    check("perr_set", 64'(protocol_err), 64'h1);
    check("perr_not_forwarded", 64'(bus.fu_valid), 64'h0);
    for (int n = 0; n < 3; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end
    check("perr_sticky", 64'(protocol_err), 64'h1);
    do_reset();

    // Flush with 2 buffered and 1 in flight
    bus.rs_req   = 4'b1111;
    bus.fu_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end
    check("flush_setup_occ", 64'(mq.size()), 64'd2);
    drive_rs(1'b1, 1'b0, '0);
    sg    = m_prev_gnt;
    flush = 1'b1;
    cycle();
    check("flush_fu_valid", 64'(bus.fu_valid), 64'h0);
    flush = 1'b0;
    drive_rs(1'b1, 1'b1, 4'b0001 << sg);
    cycle();
    check("flush_stale_no_err", 64'(protocol_err), 64'h0);
    bus.fu_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end

    // Asynchronous reset between clock edges mid-stream
    for (int n = 0; n < 3; n++) begin
      drive_rs(1'b1, 1'b0, '0);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 64'(bus.rs_busy), 64'hF);
    check("async_fu_valid", 64'(bus.fu_valid), 64'h0);
    check("async_fu_data", 64'({bus.fu_instr_index, bus.fu_instr_full, bus.fu_val1, bus.fu_val2}), 64'h0);
    do_reset();

    // Randomized traffic: requests, FU stalls, dropped valids and flushes
    for (int n = 0; n < 2000; n++) begin
      bus.rs_req   = 4'($urandom);
      bus.fu_ready = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 31) == 0);
      drive_rs($urandom_range(0, 7) != 0, 1'b0, '0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
